memx_ctrl: RTL
==============

MEMX_CTRL -- requirements
Module: memx_ctrl

Interface
REQ-001 Parameter: ADDR_W, 8, address width of the MemX word array (256 words).
REQ-002 Parameter: HALF_W, 32, width of each MemX half; the full word is 2*HALF_W, with upper half = Product and lower half = C.
REQ-003 Port: clock  in  1  single clock for all state; SRAMs sample on its rising edge.
REQ-004 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: wr_req  in  1  write request; held high until wr_gnt.
REQ-006 Port: wr_addr  in  ADDR_W  write address; sampled in the wr_gnt cycle.
REQ-007 Port: wr_data  in  2*HALF_W  write word {Product,C}; sampled in the wr_gnt cycle.
REQ-008 Port: wr_gnt  out  1  one-cycle write grant.
REQ-009 Port: rd_req, rd_addr  in  1, ADDR_W  read request and read address; same hold rules as write.
REQ-010 Port: rd_gnt  out  1  one-cycle read grant.
REQ-011 Port: rd_valid, rd_data  out  1, 2*HALF_W  read-return strobe and read-return word.
REQ-012 Port: clr_start  in  1  pulse that starts a zero-fill of all 256 words.
REQ-013 Port: clr_busy, clr_done  out  1, 1  clear-in-progress level and one-cycle completion pulse.
REQ-014 Port: common_address  out  ADDR_W  shared SRAM address.
REQ-015 Port: Product, C  out  HALF_W each  SRAM data-in, upper half and lower half.
REQ-016 Port: WrtEnbX, notWrtEnbX  out  1, 1  write strobe and read strobe; both high-active.
REQ-017 Port: memX_dataout  in  2*HALF_W  SRAM read data; stable in the cycle after the read strobe.

Function
REQ-018 All outputs in REQ-008 to REQ-016 shall be registered.
- At most one SRAM command per cycle.
- WrtEnbX and notWrtEnbX shall never be high together.
- When idle, both strobes are low, and common_address, Product and C hold their last values.
REQ-019 FSM states: IDLE, ACCESS, CLEAR.
- IDLE->ACCESS when a request wins arbitration.
- ACCESS->IDLE after one cycle, or ACCESS->ACCESS if a further request wins.
- IDLE/ACCESS->CLEAR on clr_start.
- CLEAR->IDLE after address 255 is written.
REQ-020 A grant pulse coincides exactly with its SRAM command cycle T.
- Write: WrtEnbX=1, common_address=wr_addr, {Product,C}=wr_data.
- Read: notWrtEnbX=1, common_address=rd_addr.
REQ-021 Request to grant: a request sampled high at edge k gets its grant and command in cycle k+1 at the earliest.
- Back-to-back grants shall be possible, giving 1 access per cycle at full throughput.
REQ-022 Arbitration is round-robin between write and read.
- On a conflict, the port not served last wins.
- The last-served flag resets to "read", so write wins the first conflict.
- A lone requester always wins.
REQ-023 Read return: for a read command in cycle T, rd_valid=1 in cycle T+2 with rd_data = memX_dataout captured at the end of T+1.
- rd_data holds its value until the next rd_valid.
REQ-024 A read at the same address as an immediately preceding granted write shall return the newly written word (no bypass logic; the ordering guarantees it).
REQ-025 Clear sequence:
- clr_busy=1 from the cycle after clr_start.
- Writes zero to addresses 0..255 in 256 consecutive cycles, in ascending order.
- The address counter is ADDR_W bits; its wrap from 255 to 0 ends the sequence.
- clr_done=1 for one cycle, in the cycle after the write to address 255.
- clr_busy drops in that same cycle.
REQ-026 During CLEAR, wr_gnt and rd_gnt stay 0; requests remain pending and are served after CLEAR.
- clr_start while clr_busy=1 is ignored.
- clr_start in the same cycle as a request: clear wins.
REQ-027 A read return in flight when CLEAR begins shall still complete per REQ-023.

Reset
REQ-028 While reset_n=0, all of the following shall be 0 regardless of clock:
- every output;
- the FSM state (IDLE);
- the clear counter;
- the read pipeline valid bits.
REQ-029 Reset asserted mid-clear or mid-read shall abandon the operation; no clr_done and no rd_valid shall appear after release.
REQ-030 After reset_n rises, the first grant shall occur no earlier than the second rising edge.

Structure
REQ-031 Shared package memx_pkg holds:
- ADDR_W, HALF_W and MEMX_DEPTH=256;
- the FSM state enum;
- the port-select enum used for last-served.
REQ-032 One sub-module, memx_rr_arb, shall implement the 2-way round-robin arbiter; the FSM, clear counter and read-return pipeline stay in memx_ctrl.

Verification
REQ-033 Write then read:
- Stimulus: write addr 0x12 data 0xDEADBEEF_01234567, then read 0x12.
- Required: WrtEnbX in the wr_gnt cycle, and rd_valid two cycles after rd_gnt with the same data.
REQ-034 Simultaneous requests:
- Stimulus: wr_req and rd_req both held high for 4 grants.
- Required: grant order write, read, write, read; never both strobes high.
REQ-035 Clear with pending read:
- Stimulus: clr_start, then rd_req to 0xFF during the clear.
- Required: 256 WrtEnbX cycles with addresses 0..255 and data 0, then clr_done, then rd_gnt, then rd_data=0.
REQ-036 Reset mid-clear:
- Stimulus: assert reset_n=0 at clear address 0x80.
- Required: all outputs 0 immediately; no clr_done after release.
REQ-037 Read-after-write back-to-back:
- Stimulus: write 0x00 with 0x1, then immediately read 0x00.
- Required: rd_data=0x1.
REQ-038 Repeated clr_start:
- Stimulus: clr_start pulsed at clear address 0x10.
- Required: the sequence continues uninterrupted; exactly one clr_done.

Source files
------------

// File: rtl/memx_pkg.sv
// Shared definitions for the MemX SRAM controller: widths, depth, FSM states
// and the port identifier used by the round-robin arbiter.
package memx_pkg;

   localparam int unsigned ADDR_W     = 8;
   localparam int unsigned HALF_W     = 32;
   localparam int unsigned MEMX_DEPTH = 256;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_CLEAR  = 2'd2
   } memx_state_e;

   typedef enum logic {
      PORT_RD = 1'b0,
      PORT_WR = 1'b1
   } memx_port_e;

endpackage

// File: rtl/memx_if.sv
// Host-side request/grant/return bundle of the MemX controller.
interface memx_if #(
   parameter int unsigned ADDR_W = memx_pkg::ADDR_W,
   parameter int unsigned HALF_W = memx_pkg::HALF_W
);
   logic                  wr_req;
   logic [ADDR_W-1:0]     wr_addr;
   logic [2*HALF_W-1:0]   wr_data;
   logic                  wr_gnt;
   logic                  rd_req;
   logic [ADDR_W-1:0]     rd_addr;
   logic                  rd_gnt;
   logic                  rd_valid;
   logic [2*HALF_W-1:0]   rd_data;
   logic                  clr_start;
   logic                  clr_busy;
   logic                  clr_done;

   modport master (
      output wr_req, wr_addr, wr_data, rd_req, rd_addr, clr_start,
      input  wr_gnt, rd_gnt, rd_valid, rd_data, clr_busy, clr_done
   );

   modport slave (
      input  wr_req, wr_addr, wr_data, rd_req, rd_addr, clr_start,
      output wr_gnt, rd_gnt, rd_valid, rd_data, clr_busy, clr_done
   );
endinterface

// File: rtl/memx_rr_arb.sv
// Two-way round-robin arbiter between the write and read ports; the port that
// was not served last wins a conflict, and the history starts at "read".
module memx_rr_arb (
   input  logic clock,
   input  logic reset_n,
   input  logic en,
   input  logic req_wr,
   input  logic req_rd,
   output logic gnt_wr_c,
   output logic gnt_rd_c
);
   import memx_pkg::*;

   memx_port_e last_q;

   always_comb begin
      gnt_wr_c = 1'b0;
      gnt_rd_c = 1'b0;
      if (en) begin
         gnt_wr_c = req_wr & (~req_rd | (last_q == PORT_RD));
         gnt_rd_c = req_rd & ~gnt_wr_c;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= PORT_RD;
      end else if (gnt_wr_c) begin
         last_q <= PORT_WR;
      end else if (gnt_rd_c) begin
         last_q <= PORT_RD;
      end
   end

endmodule

// File: rtl/memx_ctrl.sv
// MemX SRAM controller: arbitrates host writes/reads onto one shared SRAM port,
// runs a full zero-fill on request and returns read data two cycles later.
module memx_ctrl #(
   parameter int unsigned ADDR_W = memx_pkg::ADDR_W,
   parameter int unsigned HALF_W = memx_pkg::HALF_W
) (
   input  logic                  clock,
   input  logic                  reset_n,
   memx_if.slave                 host,
   output logic [ADDR_W-1:0]     common_address,
   output logic [HALF_W-1:0]     Product,
   output logic [HALF_W-1:0]     C,
   output logic                  WrtEnbX,
   output logic                  notWrtEnbX,
   input  logic [2*HALF_W-1:0]   memX_dataout
);
   import memx_pkg::*;

   localparam int unsigned WORD_W = 2 * HALF_W;

   memx_state_e        state_q;
   logic [ADDR_W-1:0]  clr_cnt_q;
   logic               ready_q;
   logic               rd_pipe_q;
   logic               wr_gnt_q;
   logic               rd_gnt_q;
   logic               rd_valid_q;
   logic [WORD_W-1:0]  rd_data_q;
   logic               clr_busy_q;
   logic               clr_done_q;

   logic clr_go_c;
   logic arb_en_c;
   logic wr_want_c;
   logic rd_want_c;
   logic gnt_wr_c;
   logic gnt_rd_c;

   // A request still high in its own grant cycle is the one just served.
   assign wr_want_c = host.wr_req & ~wr_gnt_q;
   assign rd_want_c = host.rd_req & ~rd_gnt_q;
   assign clr_go_c  = host.clr_start & (state_q != ST_CLEAR);
   assign arb_en_c  = ready_q & ~clr_go_c & (state_q != ST_CLEAR);

   memx_rr_arb u_arb (
      .clock    (clock),
      .reset_n  (reset_n),
      .en       (arb_en_c),
      .req_wr   (wr_want_c),
      .req_rd   (rd_want_c),
      .gnt_wr_c (gnt_wr_c),
      .gnt_rd_c (gnt_rd_c)
   );

   assign host.wr_gnt   = wr_gnt_q;
   assign host.rd_gnt   = rd_gnt_q;
   assign host.rd_valid = rd_valid_q;
   assign host.rd_data  = rd_data_q;
   assign host.clr_busy = clr_busy_q;
   assign host.clr_done = clr_done_q;

   // FSM, clear counter, SRAM command register and read-return pipeline.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         clr_cnt_q      <= '0;
         ready_q        <= 1'b0;
         rd_pipe_q      <= 1'b0;
         wr_gnt_q       <= 1'b0;
         rd_gnt_q       <= 1'b0;
         rd_valid_q     <= 1'b0;
         rd_data_q      <= '0;
         clr_busy_q     <= 1'b0;
         clr_done_q     <= 1'b0;
         common_address <= '0;
         Product        <= '0;
         C              <= '0;
         WrtEnbX        <= 1'b0;
         notWrtEnbX     <= 1'b0;
      end else begin
         ready_q    <= 1'b1;
         wr_gnt_q   <= 1'b0;
         rd_gnt_q   <= 1'b0;
         clr_done_q <= 1'b0;
         WrtEnbX    <= 1'b0;
         notWrtEnbX <= 1'b0;

         // SRAM data is stable the cycle after the strobe; return it one later.
         rd_pipe_q  <= notWrtEnbX;
         rd_valid_q <= rd_pipe_q;
         if (rd_pipe_q) begin
            rd_data_q <= memX_dataout;
         end

         unique case (state_q)
            ST_CLEAR: begin
               if (clr_cnt_q == '0) begin
                  state_q    <= ST_IDLE;
                  clr_busy_q <= 1'b0;
                  clr_done_q <= 1'b1;
               end else begin
                  WrtEnbX        <= 1'b1;
                  common_address <= clr_cnt_q;
                  Product        <= '0;
                  C              <= '0;
                  clr_cnt_q      <= clr_cnt_q + ADDR_W'(1);
               end
            end
            default: begin
               if (clr_go_c) begin
                  state_q        <= ST_CLEAR;
                  clr_busy_q     <= 1'b1;
                  WrtEnbX        <= 1'b1;
                  common_address <= '0;
                  Product        <= '0;
                  C              <= '0;
                  clr_cnt_q      <= ADDR_W'(1);
               end else if (gnt_wr_c) begin
                  state_q         <= ST_ACCESS;
                  wr_gnt_q        <= 1'b1;
                  WrtEnbX         <= 1'b1;
                  common_address  <= host.wr_addr;
                  {Product, C}    <= host.wr_data;
               end else if (gnt_rd_c) begin
                  state_q        <= ST_ACCESS;
                  rd_gnt_q       <= 1'b1;
                  notWrtEnbX     <= 1'b1;
                  common_address <= host.rd_addr;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule
